arf_variance_seq: RTL and testbench
===================================

Name: arf_variance_seq

Overview:
- Resource-shared, sequential successor to the combinational ARF-variance dataflow block.
- Evaluates the same 28-operation DFG (16 multiplies, 12 adds) on one shared multiply/add unit under a fixed one-operation-per-cycle schedule.
- Coefficients and offsets arrive as runtime inputs instead of hard-wired constants; data widths are parametrised; valid/ready handshakes on both sides.
- Sits as a schedulable datapath tile in the DFG scheduling test designs.

Parameters:
- DATA_W, 16, signed operand width of x, coefficient and offset inputs.
- ACC_W, 64, accumulator/output width; must be >= 2*DATA_W.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous assert, active low.
- in_valid  in  1  input bundle valid.
- in_ready  out  1  block can accept a bundle.
- x_i  in  8*DATA_W  samples x[0..7], x[j] = x_i[j*DATA_W +: DATA_W], signed.
- coef_i  in  16*DATA_W  coefficients c[0..15], packed the same way, signed.
- k_i  in  2*DATA_W  offsets k[0..1], signed.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- y0_o  out  ACC_W  result s27, signed.
- y1_o  out  ACC_W  result s28, signed.

Behaviour:
- Reset (async, rst_n=0): state IDLE, all counters and internal registers 0, in_ready=0 while in reset, out_valid=0, y0_o=y1_o=0.
- Reset mid-operation: abandons the computation; no partial result is ever presented.
- Accept: in IDLE, in_ready=1. On an edge with in_valid&in_ready, register x_i, coef_i and k_i, then go to MUL1 with cnt=0.
- Input stability: inputs are sampled only at accept; later changes are ignored.
- Arithmetic:
  - Product = full 2*DATA_W signed product, sign-extended to ACC_W from the product MSB.
  - Adds are ACC_W wide and wrap modulo 2^ACC_W.
  - Offsets k are sign-extended to ACC_W.
  - Second- and third-level multiplies take narrow(s), a DATA_W-wide value; default narrow(s) = s[DATA_W-1:0].
- Schedule (one op per cycle; cnt counts within a state, then resets to 0 on the transition):
  - MUL1, 8 cycles: p[cnt] = x[cnt]*c[cnt].
  - ADD1, 4 cycles: s9=p0+p1, s10=p2+p3, s11=p4+p5, s12=p6+p7.
  - ADD2, 2 cycles: s13=s10+k0, s14=s11+k1.
  - MUL2, 4 cycles: m15=n(s13)*c8, m16=n(s14)*c9, m17=n(s13)*c10, m18=n(s14)*c11.
  - ADD3, 2 cycles: s19=m15+m16, s20=m17+m18.
  - MUL3, 4 cycles: m21=n(s19)*c12, m22=n(s20)*c13, m23=n(s19)*c14, m24=n(s20)*c15.
  - ADD4, 4 cycles: s25=m21+m22, s26=m23+m24, s27=s9+s25, s28=s12+s26; then go to DONE.
- Latency: out_valid rises exactly 28 edges after the accept edge.
- DONE: out_valid=1; y0_o=s27 and y1_o=s28 are held stable while out_ready=0.
- Output handshake: on out_valid&out_ready go to IDLE.
  - out_valid falls the next cycle.
  - y0_o/y1_o keep their last value until the next DONE.
- in_ready=0 in every state except IDLE, so there are no overlapping bundles. Minimum initiation interval is 30 cycles (accept, 28 compute, DONE), with 1 cycle back in IDLE.
- out_ready asserted outside DONE is ignored.

Optional Feature:
- Macro ARF_SAT_EN.
- Defined: narrow(s) saturates to [-2^(DATA_W-1), 2^(DATA_W-1)-1] and sets sticky output flag sat_o (extra port, 1 bit). sat_o clears on accept and resets to 0.
- Undefined: narrow(s) truncates; there is no sat_o port.

Decomposition:
- Package arf_pkg:
  - state enum (IDLE, MUL1, ADD1, ADD2, MUL2, ADD3, MUL3, ADD4, DONE);
  - per-state cycle counts;
  - ARF_LATENCY=28;
  - NUM_X=8, NUM_COEF=16, NUM_K=2.
- Sub-module arf_alu: combinational shared unit. Selects op (MUL/ADD), takes two ACC_W operands, returns an ACC_W result, including sign-extension and narrowing. The FSM, operand muxing and register file stay in the top.

Test Plan:
- x=all 1, c=all 3 except c12=c13=c14=-3, k=0 -> after 28 cycles y0=-210, y1=6, out_valid held.
- Same bundle, k0=10, k1=-6 -> y0=-210+(-3)(3)(16)+(-3)(3)(0)... computed by reference model; check exact match and latency 28.
- out_ready low 5 cycles in DONE -> outputs stable, in_ready=0, new in_valid ignored; on out_ready the next bundle is accepted 2 cycles later.
- x[0]=0x7FFF, c0=0x7FFF, others 0 -> y0 = 0x3FFF0001 sign-extended; narrow path truncates (or saturates with sat_o=1 when ARF_SAT_EN is defined).
- rst_n pulsed low at cycle 12 of a computation -> out_valid never asserts; in_ready=1 the cycle after release; the next bundle produces the correct result.
- 200 random bundles with random out_ready stalls, compared against a combinational reference model -> every result matches, no drops or duplicates.

Source files
------------

// File: rtl/arf_pkg.sv
// Shared types and schedule constants for the sequential ARF-variance tile.
// The optional ARF_SAT_EN build (saturating narrow plus sat_o) is handled in the ALU and the top.
package arf_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StMul1,
        StAdd1,
        StAdd2,
        StMul2,
        StAdd3,
        StMul3,
        StAdd4,
        StDone
    } arf_state_e;

    typedef enum logic {
        AluAdd,
        AluMul
    } alu_op_e;

    localparam int unsigned NUM_X    = 8;
    localparam int unsigned NUM_COEF = 16;
    localparam int unsigned NUM_K    = 2;

    localparam int unsigned MUL1_CYC = 8;
    localparam int unsigned ADD1_CYC = 4;
    localparam int unsigned ADD2_CYC = 2;
    localparam int unsigned MUL2_CYC = 4;
    localparam int unsigned ADD3_CYC = 2;
    localparam int unsigned MUL3_CYC = 4;
    localparam int unsigned ADD4_CYC = 4;

    localparam int unsigned ARF_LATENCY = MUL1_CYC + ADD1_CYC + ADD2_CYC + MUL2_CYC
                                        + ADD3_CYC + MUL3_CYC + ADD4_CYC;
    localparam int unsigned STEP_W = 5;

    // Value of cnt on the last cycle of a compute state.
    function automatic logic [2:0] state_last(input arf_state_e st);
        case (st)
            StMul1:  return 3'(MUL1_CYC - 1);
            StAdd1:  return 3'(ADD1_CYC - 1);
            StAdd2:  return 3'(ADD2_CYC - 1);
            StMul2:  return 3'(MUL2_CYC - 1);
            StAdd3:  return 3'(ADD3_CYC - 1);
            StMul3:  return 3'(MUL3_CYC - 1);
            StAdd4:  return 3'(ADD4_CYC - 1);
            default: return 3'd0;
        endcase
    endfunction

    // Global op index of cnt=0 within each state; op n writes result register n.
    function automatic logic [STEP_W-1:0] state_base(input arf_state_e st);
        case (st)
            StAdd1:  return STEP_W'(MUL1_CYC);
            StAdd2:  return STEP_W'(MUL1_CYC + ADD1_CYC);
            StMul2:  return STEP_W'(MUL1_CYC + ADD1_CYC + ADD2_CYC);
            StAdd3:  return STEP_W'(MUL1_CYC + ADD1_CYC + ADD2_CYC + MUL2_CYC);
            StMul3:  return STEP_W'(MUL1_CYC + ADD1_CYC + ADD2_CYC + MUL2_CYC + ADD3_CYC);
            StAdd4:  return STEP_W'(ARF_LATENCY - ADD4_CYC);
            default: return '0;
        endcase
    endfunction

    function automatic arf_state_e state_next(input arf_state_e st);
        case (st)
            StMul1:  return StAdd1;
            StAdd1:  return StAdd2;
            StAdd2:  return StMul2;
            StMul2:  return StAdd3;
            StAdd3:  return StMul3;
            StMul3:  return StAdd4;
            StAdd4:  return StDone;
            default: return StIdle;
        endcase
    endfunction

endpackage

// File: rtl/arf_alu.sv
// Shared combinational multiply/add unit: narrows multiply operands to DATA_W, forms the full
// signed product and sign-extends it to ACC_W; adds wrap at ACC_W. ARF_SAT_EN makes narrow saturate.
module arf_alu
    import arf_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 64
) (
    input  alu_op_e                  op,
    input  logic signed [ACC_W-1:0]  a,
    input  logic signed [ACC_W-1:0]  b,
`ifdef ARF_SAT_EN
    output logic                     sat,
`endif
    output logic signed [ACC_W-1:0]  res
);

    logic signed [DATA_W-1:0]   na;
    logic signed [DATA_W-1:0]   nb;
    logic signed [2*DATA_W-1:0] prod;

`ifdef ARF_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    logic sat_a;
    logic sat_b;
`endif

    always_comb begin
        na = a[DATA_W-1:0];
        nb = b[DATA_W-1:0];
`ifdef ARF_SAT_EN
        sat_a = 1'b0;
        sat_b = 1'b0;
        if (a > SAT_MAX) begin
            na    = SAT_MAX[DATA_W-1:0];
            sat_a = 1'b1;
        end else if (a < SAT_MIN) begin
            na    = SAT_MIN[DATA_W-1:0];
            sat_a = 1'b1;
        end
        if (b > SAT_MAX) begin
            nb    = SAT_MAX[DATA_W-1:0];
            sat_b = 1'b1;
        end else if (b < SAT_MIN) begin
            nb    = SAT_MIN[DATA_W-1:0];
            sat_b = 1'b1;
        end
        sat = (op == AluMul) && (sat_a || sat_b);
`endif
        prod = $signed({{DATA_W{na[DATA_W-1]}}, na}) * $signed({{DATA_W{nb[DATA_W-1]}}, nb});
        if (op == AluMul) begin
            res = ACC_W'(prod);
        end else begin
            res = a + b;
        end
    end

endmodule

// File: rtl/arf_variance_seq.sv
// Sequential ARF-variance tile: evaluates the 28-op DFG on one shared ALU, one op per cycle.
// Define ARF_SAT_EN for saturating narrowing and the sticky sat_o flag.
module arf_variance_seq
    import arf_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_X*DATA_W-1:0]      x_i,
    input  logic [NUM_COEF*DATA_W-1:0]   coef_i,
    input  logic [NUM_K*DATA_W-1:0]      k_i,
    output logic                         out_valid,
    input  logic                         out_ready,
`ifdef ARF_SAT_EN
    output logic                         sat_o,
`endif
    output logic [ACC_W-1:0]             y0_o,
    output logic [ACC_W-1:0]             y1_o
);

    arf_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;

    logic signed [DATA_W-1:0] x_q [NUM_X];
    logic signed [DATA_W-1:0] c_q [NUM_COEF];
    logic signed [DATA_W-1:0] k_q [NUM_K];
    // Result of op n lands in rf_q[n]; the final op goes straight to y1_q.
    logic signed [ACC_W-1:0]  rf_q [ARF_LATENCY-1];
    logic signed [ACC_W-1:0]  y0_q, y1_q;

    logic              accept;
    logic              busy;
    logic [STEP_W-1:0] step;
    alu_op_e           alu_op;
    logic signed [ACC_W-1:0] alu_a, alu_b, alu_res;

`ifdef ARF_SAT_EN
    logic alu_sat;
    logic sat_q;
    assign sat_o = sat_q;
`endif

    assign in_ready  = rst_n && (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q != StIdle) && (state_q != StDone);
    assign step      = state_base(state_q) + STEP_W'(cnt_q);
    assign y0_o      = y0_q;
    assign y1_o      = y1_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StMul1;
                    cnt_d   = '0;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: begin
                if (cnt_q == state_last(state_q)) begin
                    state_d = state_next(state_q);
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
        endcase
    end

    always_comb begin
        alu_op = AluAdd;
        alu_a  = '0;
        alu_b  = '0;
        if (step < STEP_W'(MUL1_CYC)) begin
            alu_op = AluMul;
            alu_a  = ACC_W'(x_q[step[2:0]]);
            alu_b  = ACC_W'(c_q[step[2:0]]);
        end else begin
            case (step)
                5'd8:  begin alu_a = rf_q[0];  alu_b = rf_q[1];  end
                5'd9:  begin alu_a = rf_q[2];  alu_b = rf_q[3];  end
                5'd10: begin alu_a = rf_q[4];  alu_b = rf_q[5];  end
                5'd11: begin alu_a = rf_q[6];  alu_b = rf_q[7];  end
                5'd12: begin alu_a = rf_q[9];  alu_b = ACC_W'(k_q[0]); end
                5'd13: begin alu_a = rf_q[10]; alu_b = ACC_W'(k_q[1]); end
                5'd14: begin alu_op = AluMul; alu_a = rf_q[12]; alu_b = ACC_W'(c_q[8]);  end
                5'd15: begin alu_op = AluMul; alu_a = rf_q[13]; alu_b = ACC_W'(c_q[9]);  end
                5'd16: begin alu_op = AluMul; alu_a = rf_q[12]; alu_b = ACC_W'(c_q[10]); end
                5'd17: begin alu_op = AluMul; alu_a = rf_q[13]; alu_b = ACC_W'(c_q[11]); end
                5'd18: begin alu_a = rf_q[14]; alu_b = rf_q[15]; end
                5'd19: begin alu_a = rf_q[16]; alu_b = rf_q[17]; end
                5'd20: begin alu_op = AluMul; alu_a = rf_q[18]; alu_b = ACC_W'(c_q[12]); end
                5'd21: begin alu_op = AluMul; alu_a = rf_q[19]; alu_b = ACC_W'(c_q[13]); end
                5'd22: begin alu_op = AluMul; alu_a = rf_q[18]; alu_b = ACC_W'(c_q[14]); end
                5'd23: begin alu_op = AluMul; alu_a = rf_q[19]; alu_b = ACC_W'(c_q[15]); end
                5'd24: begin alu_a = rf_q[20]; alu_b = rf_q[21]; end
                5'd25: begin alu_a = rf_q[22]; alu_b = rf_q[23]; end
                5'd26: begin alu_a = rf_q[8];  alu_b = rf_q[24]; end
                5'd27: begin alu_a = rf_q[11]; alu_b = rf_q[25]; end
                default: ;
            endcase
        end
    end

    arf_alu #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_alu (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
`ifdef ARF_SAT_EN
        .sat(alu_sat),
`endif
        .res(alu_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_X; i++) x_q[i] <= '0;
            for (int i = 0; i < NUM_COEF; i++) c_q[i] <= '0;
            for (int i = 0; i < NUM_K; i++) k_q[i] <= '0;
            for (int i = 0; i < ARF_LATENCY - 1; i++) rf_q[i] <= '0;
            y0_q <= '0;
            y1_q <= '0;
`ifdef ARF_SAT_EN
            sat_q <= 1'b0;
`endif
        end else begin
            if (accept) begin
                for (int i = 0; i < NUM_X; i++) x_q[i] <= x_i[i*DATA_W +: DATA_W];
                for (int i = 0; i < NUM_COEF; i++) c_q[i] <= coef_i[i*DATA_W +: DATA_W];
                for (int i = 0; i < NUM_K; i++) k_q[i] <= k_i[i*DATA_W +: DATA_W];
`ifdef ARF_SAT_EN
                sat_q <= 1'b0;
`endif
            end
            if (busy) begin
                // Outputs only move on the final op so they hold their last value until DONE.
                if (step < STEP_W'(ARF_LATENCY - 1)) begin
                    rf_q[step] <= alu_res;
                end else begin
                    y0_q <= rf_q[ARF_LATENCY-2];
                    y1_q <= alu_res;
                end
`ifdef ARF_SAT_EN
                sat_q <= sat_q | alu_sat;
`endif
            end
        end
    end

endmodule

// File: tb/tb_arf_variance_seq.sv
// Scoreboard bench for arf_variance_seq: directed vectors with hand-derived results plus
// random bundles against a dataflow reference model, under random output stalls.
module tb_arf_variance_seq;

    localparam int DW = 16;
    localparam int AW = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [8*DW-1:0] x_i = '0;
    logic [16*DW-1:0] coef_i = '0;
    logic [2*DW-1:0] k_i = '0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [AW-1:0]   y0_o, y1_o;
`ifdef ARF_SAT_EN
    logic            sat_o;
`endif

    typedef struct {
        logic [63:0] y0;
        logic [63:0] y1;
        logic        sat;
        int          acc;
    } exp_t;

    exp_t sbq[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int or_mode = 0;
    int last_acc = 0;
    int last_hs = 0;
    logic prev_valid = 1'b0;

    logic signed [15:0] xv[8];
    logic signed [15:0] cv[16];
    logic signed [15:0] kv[2];

    arf_variance_seq #(.DATA_W(DW), .ACC_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_i      (x_i),
        .coef_i   (coef_i),
        .k_i      (k_i),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef ARF_SAT_EN
        .sat_o    (sat_o),
`endif
        .y0_o     (y0_o),
        .y1_o     (y1_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, $signed(act), $signed(exp));
        end
    endtask

    function automatic logic signed [15:0] nrw(input logic signed [63:0] s);
`ifdef ARF_SAT_EN
        if (s > 64'sd32767) return 16'sd32767;
        if (s < -64'sd32768) return -16'sd32768;
`endif
        return s[15:0];
    endfunction

    function automatic logic oor(input logic signed [63:0] s);
        return (s > 64'sd32767) || (s < -64'sd32768);
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic signed [63:0] p[8];
        logic signed [63:0] s9, s10, s11, s12, s13, s14, m15, m16, m17, m18;
        logic signed [63:0] s19, s20, m21, m22, m23, m24, s25, s26;
        for (int i = 0; i < 8; i++) p[i] = 64'(xv[i]) * 64'(cv[i]);
        s9  = p[0] + p[1];
        s10 = p[2] + p[3];
        s11 = p[4] + p[5];
        s12 = p[6] + p[7];
        s13 = s10 + 64'(kv[0]);
        s14 = s11 + 64'(kv[1]);
        m15 = 64'(nrw(s13)) * 64'(cv[8]);
        m16 = 64'(nrw(s14)) * 64'(cv[9]);
        m17 = 64'(nrw(s13)) * 64'(cv[10]);
        m18 = 64'(nrw(s14)) * 64'(cv[11]);
        s19 = m15 + m16;
        s20 = m17 + m18;
        m21 = 64'(nrw(s19)) * 64'(cv[12]);
        m22 = 64'(nrw(s20)) * 64'(cv[13]);
        m23 = 64'(nrw(s19)) * 64'(cv[14]);
        m24 = 64'(nrw(s20)) * 64'(cv[15]);
        s25 = m21 + m22;
        s26 = m23 + m24;
        e.y0 = s9 + s25;
        e.y1 = s12 + s26;
`ifdef ARF_SAT_EN
        e.sat = oor(s13) || oor(s14) || oor(s19) || oor(s20);
`else
        e.sat = 1'b0;
`endif
        e.acc = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [63:0] y0, input logic [63:0] y1, input logic sat);
        exp_t e;
        e.y0 = y0;
        e.y1 = y1;
        e.sat = sat;
        e.acc = 0;
        return e;
    endfunction

    task automatic clear_vec();
        for (int i = 0; i < 8; i++) xv[i] = '0;
        for (int i = 0; i < 16; i++) cv[i] = '0;
        kv[0] = '0;
        kv[1] = '0;
    endtask

    task automatic base_vec();
        for (int i = 0; i < 8; i++) xv[i] = 16'sd1;
        for (int i = 0; i < 16; i++) cv[i] = 16'sd3;
        cv[12] = -16'sd3;
        cv[13] = -16'sd3;
        cv[14] = -16'sd3;
        kv[0] = '0;
        kv[1] = '0;
    endtask

    task automatic send(input exp_t e);
        exp_t t;
        int n;
        t = e;
        n = 0;
        for (int i = 0; i < 8; i++) x_i[i*DW +: DW] = xv[i];
        for (int i = 0; i < 16; i++) coef_i[i*DW +: DW] = cv[i];
        for (int i = 0; i < 2; i++) k_i[i*DW +: DW] = kv[i];
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
            in_valid = 1'b0;
            return;
        end
        t.acc = cyc + 1;
        last_acc = t.acc;
        sbq.push_back(t);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Garbage after accept: the DUT must not resample.
        for (int i = 0; i < 8; i++) x_i[i*DW +: DW] = 16'($urandom);
        for (int i = 0; i < 16; i++) coef_i[i*DW +: DW] = 16'($urandom);
        k_i = 32'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(sbq.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (out_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got y0=%0d expected no result", $signed(y0_o));
                end else begin
                    if (!prev_valid) chk("latency", 64'(cyc - sbq[0].acc), 64'd28);
                    chk("y0", y0_o, sbq[0].y0);
                    chk("y1", y1_o, sbq[0].y1);
`ifdef ARF_SAT_EN
                    chk("sat", 64'(sat_o), 64'(sbq[0].sat));
`endif
                    chk("in_ready_in_done", 64'(in_ready), 64'd0);
                    if (out_ready) begin
                        void'(sbq.pop_front());
                        last_hs = cyc + 1;
                    end
                end
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        int bad;
        int n;
        exp_t e;
        repeat (2) @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_y0", y0_o, 64'd0);
        chk("reset_y1", y1_o, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Uniform bundle: p=3, s13=s14=6, m=18, s19=s20=36 -> y0=6-216, y1=6+0.
        base_vec();
        send(mk(-64'sd210, 64'sd6, 1'b0));
        drain();

        // k0=10, k1=-6: s13=16, s14=0 -> s19=s20=48 -> y0=6-288, y1=6.
        base_vec();
        kv[0] = 16'sd10;
        kv[1] = -16'sd6;
        send(mk(-64'sd282, 64'sd6, 1'b0));
        drain();

        // Largest positive product lands in s9 only.
        clear_vec();
        xv[0] = 16'sh7FFF;
        cv[0] = 16'sh7FFF;
        send(mk(64'h0000_0000_3FFF_0001, 64'd0, 1'b0));
        drain();

        // s13 = 0x3FFF0001 goes through narrow: truncates to 1, or saturates to 32767.
        clear_vec();
        xv[2] = 16'sh7FFF;
        cv[2] = 16'sh7FFF;
        cv[8] = 16'sd1;
        cv[12] = 16'sd1;
`ifdef ARF_SAT_EN
        send(mk(64'sd32767, 64'd0, 1'b1));
`else
        send(mk(64'sd1, 64'd0, 1'b0));
`endif
        drain();

        // Stall in DONE for several cycles while a second bundle waits at the input.
        or_mode = 1;
        base_vec();
        send(mk(-64'sd210, 64'sd6, 1'b0));
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_reach_done", 64'(out_valid), 64'd1);
        kv[0] = 16'sd10;
        kv[1] = -16'sd6;
        fork
            send(mk(-64'sd282, 64'sd6, 1'b0));
            begin
                repeat (5) @(negedge clk);
                or_mode = 0;
            end
        join
        chk("accept_after_handshake", 64'(last_acc), 64'(last_hs + 1));
        drain();

        // Reset in the middle of a computation: nothing may come out.
        base_vec();
        send(mk(-64'sd210, 64'sd6, 1'b0));
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        chk("midreset_in_ready", 64'(in_ready), 64'd0);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) bad++;
        end
        chk("no_partial_result", 64'(bad), 64'd0);
        @(posedge clk);
        #1;
        base_vec();
        kv[0] = 16'sd10;
        kv[1] = -16'sd6;
        send(mk(-64'sd282, 64'sd6, 1'b0));
        drain();

        // Random bundles with random output stalls.
        or_mode = 2;
        for (int r = 0; r < 200; r++) begin
            for (int i = 0; i < 8; i++) xv[i] = 16'($urandom);
            for (int i = 0; i < 16; i++) cv[i] = 16'($urandom);
            kv[0] = 16'($urandom);
            kv[1] = 16'($urandom);
            e = model();
            send(e);
        end
        drain();
        or_mode = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
